// File: rtl/wwd_display_buffer.sv
// -----------------------------------------------------------------------------
// wwd_display_buffer
// Buffers committed WWD results in a small FIFO and shows the head entry on a
// four-digit multiplexed 7-segment display (active-low segments and anodes).
// The led output mirrors the CPU PC low byte one cycle late.
//
// Optional feature macro: WWD_DISPLAY_BLANK_EN
//   When defined, leading zero digits (k>0) are blanked; digit 0 always shows.
// -----------------------------------------------------------------------------
module wwd_display_buffer #(
   parameter int SCAN_DIV = 50000,
   parameter int DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset_cpu,
   input  logic [15:0] word_in,
   input  logic        word_valid,
   input  logic [7:0]  pc_in,
   input  logic        pop,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [7:0]  led,
   output logic [4:0]  fifo_count,
   output logic        empty,
   output logic        overflow
);

   localparam int          PW        = $clog2(DEPTH);
   localparam logic [4:0]  DEPTH_C   = 5'(DEPTH);
   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
   localparam logic [6:0]  SEG_DASH  = 7'b0111111;
   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [3:0]  AN_RESET  = 4'b1110;

   // Active-low glyph for one hex nibble, seg[0]=a .. seg[6]=g; b and d lowercase.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         4'hF:    g = 7'h0E;
         default: g = SEG_DASH;
      endcase
      return g;
   endfunction

   // Storage and state
   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [4:0]    count_q, count_d;
   logic          empty_q, empty_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    led_q;
   logic [15:0]   scan_q, scan_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   // Decoded strobes
   logic          full_s;
   logic          is_empty_s;
   logic          push_ok_s;
   logic          pop_ok_s;
   logic          ovf_set_s;
   logic [15:0]   head_word_s;
   logic [3:0]    nibble_s;
   logic          blank_s;

   // FIFO next-state: accept/reject push and pop, update pointers, count and flags
   always_comb begin
      full_s     = (count_q == DEPTH_C);
      is_empty_s = (count_q == 5'd0);
      pop_ok_s   = pop && !is_empty_s;
      // A full FIFO still accepts a push when the same cycle frees the head slot.
      push_ok_s  = word_valid && (!full_s || pop_ok_s);
      ovf_set_s  = word_valid && full_s && !pop;

      head_d = head_q;
      tail_d = tail_q;
      if (pop_ok_s) begin
         head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         head_d = head_q;
      end
      if (push_ok_s) begin
         tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         tail_d = tail_q;
      end

      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
      empty_d    = (count_d == 5'd0);
      overflow_d = overflow_q || ovf_set_s;
   end

   // FIFO control registers and PC mirror
   always_ff @(posedge clk) begin
      if (reset_cpu) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= 5'd0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         led_q      <= 8'h00;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         led_q      <= pc_in;
      end
   end

   // FIFO data storage; contents need no reset because pointers define validity
   always_ff @(posedge clk) begin
      if (!reset_cpu && push_ok_s) begin
         mem_q[tail_q] <= word_in;
      end
   end

   // Scan timing: digit dwell counter and digit index
   always_comb begin
      if (scan_q == SCAN_LAST) begin
         scan_d = 16'd0;
         idx_d  = idx_q + 2'd1;
      end else begin
         scan_d = scan_q + 16'd1;
         idx_d  = idx_q;
      end
   end

   // Display decode for the current digit from the current head entry
   always_comb begin
      head_word_s = mem_q[head_q];
      case (idx_q)
         2'd0:    nibble_s = head_word_s[3:0];
         2'd1:    nibble_s = head_word_s[7:4];
         2'd2:    nibble_s = head_word_s[11:8];
         2'd3:    nibble_s = head_word_s[15:12];
         default: nibble_s = 4'h0;
      endcase
`ifdef WWD_DISPLAY_BLANK_EN
      case (idx_q)
         2'd1:    blank_s = (head_word_s[15:4] == 12'h000);
         2'd2:    blank_s = (head_word_s[15:8] == 8'h00);
         2'd3:    blank_s = (head_word_s[15:12] == 4'h0);
         default: blank_s = 1'b0;
      endcase
`else
      blank_s = 1'b0;
`endif
      an_d = ~(4'b0001 << idx_q);
      if (empty_q) begin
         seg_d = SEG_DASH;
      end else if (blank_s) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = hex_glyph(nibble_s);
      end
   end

   // Display registers: anode and segment outputs change together
   always_ff @(posedge clk) begin
      if (reset_cpu) begin
         scan_q <= 16'd0;
         idx_q  <= 2'd0;
         an_q   <= AN_RESET;
         seg_q  <= SEG_DASH;
      end else begin
         scan_q <= scan_d;
         idx_q  <= idx_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign led        = led_q;
   assign fifo_count = count_q;
   assign empty      = empty_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_wwd_display_buffer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for wwd_display_buffer (SCAN_DIV=4, DEPTH=4).
// Expected glyphs are active-low, seg[0]=a .. seg[6]=g.
// -----------------------------------------------------------------------------
module tb_wwd_display_buffer;

   logic        clk = 1'b0;
   logic        reset_cpu = 1'b1;
   logic [15:0] word_in = 16'h0000;
   logic        word_valid = 1'b0;
   logic [7:0]  pc_in = 8'h00;
   logic        pop = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [7:0]  led;
   logic [4:0]  fifo_count;
   logic        empty;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   wwd_display_buffer #(.SCAN_DIV(4), .DEPTH(4)) dut (
      .clk        (clk),
      .reset_cpu  (reset_cpu),
      .word_in    (word_in),
      .word_valid (word_valid),
      .pc_in      (pc_in),
      .pop        (pop),
      .seg        (seg),
      .an         (an),
      .led        (led),
      .fifo_count (fifo_count),
      .empty      (empty),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for the first cycle in which an becomes target (bounded).
   task automatic wait_an(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      while (an === target && n < 64) begin tick(); n++; end
      while (an !== target && n < 64) begin tick(); n++; end
      if (n >= 64) begin
         checks++;
         errors++;
         $error("FAIL %s timeout an=%b expected=%b", tag, an, target);
      end
   endtask

   task automatic check_digit(input int k, input logic [6:0] exp, input string tag);
      logic [3:0] target;
      target = ~(4'b0001 << k);
      wait_an(target, tag);
      check(tag, {25'd0, seg}, {25'd0, exp});
   endtask

   task automatic push(input logic [15:0] w);
      word_in = w; word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
   endtask

   task automatic do_pop();
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      reset_cpu = 1'b0;
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_led", 32'(led), 32'h00);
      check("rst_an", 32'(an), 32'hE);
      check("rst_seg", 32'(seg), 32'h3F);

      // Single push and scan sequence
      push(16'h0300);
      check("push1_count", 32'(fifo_count), 32'd1);
      check("push1_empty", 32'(empty), 32'd0);
      wait_an(4'b1110, "scan_start");
      repeat (4) tick();
      check("scan_an1", 32'(an), 32'hD);
      repeat (4) tick();
      check("scan_an2", 32'(an), 32'hB);
      check("scan_dig2_3", 32'(seg), 32'h30);
      repeat (4) tick();
      check("scan_an3", 32'(an), 32'h7);
      check("scan_dig3_0", 32'(seg), 32'h40);
      repeat (4) tick();
      check("scan_an0", 32'(an), 32'hE);
      check("scan_dig0_0", 32'(seg), 32'h40);

      // Pop to empty, then pop while empty
      do_pop();
      check("pop1_count", 32'(fifo_count), 32'd0);
      check("pop1_empty", 32'(empty), 32'd1);
      tick();
      check("empty_dash", 32'(seg), 32'h3F);
      do_pop();
      check("pop_empty_count", 32'(fifo_count), 32'd0);

      // led delay
      pc_in = 8'h15;
      check("led_before", 32'(led), 32'h00);
      tick();
      check("led_15", 32'(led), 32'h15);
      pc_in = 8'hA7;
      tick();
      check("led_a7", 32'(led), 32'hA7);

      // Overfill
      for (int i = 1; i <= 5; i++) push(16'(i));
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_ovf", 32'(overflow), 32'd1);
      tick();
      check_digit(0, 7'h79, "head_1");
      check_digit(1, 7'h40, "head_1_d1");
      do_pop(); tick();
      check_digit(0, 7'h24, "head_2");
      do_pop(); tick();
      check_digit(0, 7'h30, "head_3");
      do_pop(); tick();
      check_digit(0, 7'h19, "head_4");
      do_pop();
      check("drain_empty", 32'(empty), 32'd1);
      tick();
      check("drain_dash", 32'(seg), 32'h3F);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Full with simultaneous push and pop
      push(16'h000A); push(16'h000B); push(16'h000C); push(16'h000D);
      check("refill_count", 32'(fifo_count), 32'd4);
      word_in = 16'hBEEF; word_valid = 1'b1; pop = 1'b1;
      tick();
      word_valid = 1'b0; pop = 1'b0;
      check("full_pp_count", 32'(fifo_count), 32'd4);
      do_pop(); do_pop(); do_pop();
      check("beef_count", 32'(fifo_count), 32'd1);
      tick();
      check_digit(0, 7'h0E, "beef_d0");
      check_digit(1, 7'h06, "beef_d1");
      check_digit(2, 7'h06, "beef_d2");
      check_digit(3, 7'h03, "beef_d3");

      // Partially filled push and pop together: head becomes 0042
      word_in = 16'h0042; word_valid = 1'b1; pop = 1'b1;
      tick();
      word_valid = 1'b0; pop = 1'b0;
      check("mid_pp_count", 32'(fifo_count), 32'd1);
      tick();
`ifdef WWD_DISPLAY_BLANK_EN
      check_digit(3, 7'h7F, "w42_d3");
      check_digit(2, 7'h7F, "w42_d2");
`else
      check_digit(3, 7'h40, "w42_d3");
      check_digit(2, 7'h40, "w42_d2");
`endif
      check_digit(1, 7'h19, "w42_d1");
      check_digit(0, 7'h24, "w42_d0");

      // Empty with push and pop together: only the push happens
      do_pop();
      check("pre_ep_empty", 32'(empty), 32'd1);
      word_in = 16'h0007; word_valid = 1'b1; pop = 1'b1;
      tick();
      word_valid = 1'b0; pop = 1'b0;
      check("empty_pp_count", 32'(fifo_count), 32'd1);
      push(16'h0001); push(16'h0002);
      check("three_count", 32'(fifo_count), 32'd3);
      tick();
      check_digit(0, 7'h78, "head_7");

      // Mid-operation reset with a strobe present in the reset cycle
      reset_cpu = 1'b1; word_in = 16'h1234; word_valid = 1'b1;
      tick();
      reset_cpu = 1'b0; word_valid = 1'b0;
      check("mrst_count", 32'(fifo_count), 32'd0);
      check("mrst_ovf", 32'(overflow), 32'd0);
      check("mrst_an", 32'(an), 32'hE);
      check("mrst_empty", 32'(empty), 32'd1);
      check("mrst_seg", 32'(seg), 32'h3F);
      tick();
      check("mrst_count2", 32'(fifo_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wwd_display_buffer.md
WWD_DISPLAY_BUFFER -- requirements
Module: wwd_display_buffer

Interface
REQ-001 Parameter SCAN_DIV, default 50000, is the number of clk cycles each digit is lit; legal range is 2..65535.
REQ-002 Parameter DEPTH, default 4, is the FIFO depth in words; it SHALL be a power of two, 2..16.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_cpu  input  1  is the reset, synchronous and active-high.
REQ-005 Port word_in  input  16  is the CPU output_port value.
REQ-006 Port word_valid  input  1  is a one-cycle strobe meaning word_in holds a committed WWD result.
REQ-007 Port pc_in  input  8  is the CPU PC_below8bit.
REQ-008 Port pop  input  1  is a one-cycle pulse (pre-debounced) that advances the display to the next buffered word.
REQ-009 Port seg  output  7  drives active-low segments, with seg[0]=a through seg[6]=g.
REQ-010 Port an  output  4  drives active-low digit enables, one-hot, with an[0] as the rightmost digit.
REQ-011 Port led  output  8  is the registered copy of pc_in.
REQ-012 Port fifo_count  output  5  is the number of buffered words, 0..DEPTH.
REQ-013 Port empty  output  1  SHALL be high when fifo_count==0.
REQ-014 Port overflow  output  1  is a sticky flag meaning a word was dropped.

Function
REQ-015 When word_valid=1 and the FIFO is not full, the block SHALL write word_in at the tail; fifo_count SHALL increment at the next edge.
REQ-016 When word_valid=1 and the FIFO is full with pop=0, the block SHALL discard the word, set overflow, and leave contents unchanged.
REQ-017 When pop=1 and the FIFO is not empty, the block SHALL remove the head word; when pop=1 and the FIFO is empty, pop SHALL be ignored.
REQ-018 Simultaneous word_valid and pop SHALL behave as follows:
- FIFO full: both occur and fifo_count is unchanged.
- FIFO empty: only the push occurs.
- Otherwise: both occur and fifo_count is unchanged.
REQ-019 Head and tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 The displayed word SHALL be the head entry; when empty, every digit SHALL show a dash (seg=7'b0111111).
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL advance 0→1→2→3→0.
REQ-022 Digit index k SHALL show nibble word[4k+3:4k] as hex 0-F using standard 7-segment glyphs, with b and d in lowercase.
REQ-023 an and seg SHALL be registered and SHALL change together on the same edge, one cycle after the index or head changes.
REQ-024 led SHALL equal pc_in delayed by exactly one cycle.
REQ-025 fifo_count, empty, and overflow SHALL be registered and SHALL reflect a push or pop one cycle after the strobe.

Reset
REQ-026 While reset_cpu=1 at an edge, the block SHALL set:
- FIFO: pointers=0, fifo_count=0, empty=1.
- Flags and outputs: overflow=0, led=0.
- Display: scan counter=0, digit index=0, an=4'b1110, seg=7'b0111111.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words and clear overflow; strobes in the reset cycle SHALL be ignored.
REQ-028 overflow SHALL be cleared only by reset.

Configuration
REQ-029 Macro WWD_DISPLAY_BLANK_EN, when defined, SHALL enable leading-zero blanking: a digit k>0 whose nibble and all higher nibbles are zero SHALL be blank (seg=7'h7F), and digit 0 is never blanked.
REQ-030 When WWD_DISPLAY_BLANK_EN is undefined, all four digits SHALL always show their hex glyph.

Verification
REQ-031 Reset, then push 16'h0300 → fifo_count=1, empty=0; with SCAN_DIV=4, an cycles 1110,1101,1011,0111 every 4 clks, and digit 2 shows "3".
REQ-032 Push five words 16'h0001..16'h0005 with DEPTH=4 → fifo_count=4, overflow=1, head=16'h0001; four pops give 1,2,3,4, then empty=1 and seg=7'b0111111.
REQ-033 FIFO full, then word_valid and pop in the same cycle with word_in=16'hBEEF → fifo_count stays 4; after three more pops, head=16'hBEEF.
REQ-034 pc_in=8'h15 → led=8'h15 exactly one cycle later; pop while empty → fifo_count stays 0.
REQ-035 Hold word 16'h0042 with the blank macro defined → digits 3 and 2 blank, digits 1 and 0 show "4" and "2"; with the macro undefined → "0042".
REQ-036 Assert reset_cpu for one cycle while 3 words are buffered and overflow=1 → fifo_count=0, overflow=0, an=4'b1110 on the next cycle.
